fp_accumulator: RTL and testbench
=================================

// Module: fp_accumulator
// PURPOSE
//  Sequential FP32 accumulation stage feeding the combinational floating adder.
//  Consumes a stream of IEEE-754 single-precision products (one convolution window)
//  and sums exactly LEN of them in strict arrival order. Emits one sum per window
//  to the downstream stage over a valid/ready handshake. Sits between the
//  multiplier array and the activation/pooling stage.
// PARAMETERS
//  WIDTH  32  operand/sum width; only 32 supported (FP32)
//  LEN    9   elements summed per window (3x3 kernel); legal range 1..255
// PORTS
//  clk_i    in   1      single clock, all state on rising edge
//  rst_n_i  in   1      synchronous, active-low reset
//  clear_i  in   1      synchronous abort of the current window
//  valid_i  in   1      data_i carries a valid product
//  data_i   in   WIDTH  FP32 product
//  ready_o  out  1      stage accepts data_i this cycle
//  sum_o    out  WIDTH  FP32 window sum, valid when valid_o=1
//  valid_o  out  1      sum_o holds a completed window
//  ready_i  in   1      downstream accepts sum_o
//  busy_o   out  1      a window is partially accumulated (state ACC)
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge): state=IDLE, acc=0, cnt=0, valid_o=0, sum_o=0,
//    busy_o=0. ready_o is forced 0 while rst_n_i=0; otherwise it is combinational.
//  accept = valid_i & ready_o; out_fire = valid_o & ready_i.
//  ready_o = (state!=DONE) | ready_i  (back-to-back windows with no bubble).
//  sum_o = acc register; valid_o = (state==DONE); busy_o = (state==ACC).
//  States:
//   IDLE: accept -> acc<=data_i (loaded, NOT added to 0, so -0.0 survives), cnt<=1;
//         go DONE if LEN==1, else ACC. No accept -> stay.
//   ACC:  accept -> acc<=acc+data_i (via adder), cnt<=cnt+1; when the accepted
//         element is the LEN-th (cnt==LEN-1) go DONE. Gaps (valid_i=0) just hold.
//   DONE: hold acc/valid_o until out_fire. out_fire & accept -> load data_i as first
//         element of next window (cnt<=1, ACC or DONE if LEN==1). out_fire & !accept
//         -> IDLE. !out_fire -> stay; ready_o=0, data_i ignored.
//  Latency: sum valid the cycle after the LEN-th accept. Throughput: one window per
//    LEN cycles with valid_i and ready_i held high.
//  Arithmetic: left-to-right order ((x0+x1)+x2)+...; rounding/NaN/Inf exactly as the
//    adder produces; no internal widening. cnt width $clog2(LEN+1).
//  clear_i: priority over everything except reset; next state IDLE, acc=0, cnt=0,
//    valid_o=0; data_i in the same cycle is dropped (ready_o still as defined, but
//    the accept has no effect). An undelivered DONE sum is discarded.
//  Reset mid-window or in DONE: identical to clear plus ready_o=0 during reset.
// STRUCTURE
//  Shared package fp_pkg: FP_WIDTH=32, FP_ZERO=32'h0000_0000, FP_ONE=32'h3F80_0000,
//    typedef enum logic [1:0] {ACC_IDLE, ACC_RUN, ACC_DONE} acc_state_t.
//  One sub-module: floating_adder_sim (a_i=acc, b_i=data_i, s_o=next sum), purely
//    combinational; this block owns all registers and control.
// TESTING (LEN=9 unless noted)
//  1. Reset, then 9 x 32'h3F80_0000 back-to-back, ready_i=1 -> sum_o=32'h4110_0000
//     (9.0), valid_o high exactly 1 cycle, the cycle after the 9th accept.
//  2. Alternating +1.0/-1.0 (3F80_0000/BF80_0000) starting +1.0, valid_i gaps every
//     other cycle -> sum_o=32'h3F80_0000; busy_o=1 throughout the gaps.
//  3. 9 x 32'h8000_0000 (-0.0) -> sum_o=32'h8000_0000 (proves first-element load).
//  4. Window done, ready_i=0 for 5 cycles while valid_i=1 -> valid_o/sum_o stable,
//     ready_o=0, no input consumed; ready_i=1 -> next window's first input accepted
//     same cycle, second window 9 x 0.5 (3F00_0000) -> 32'h4090_0000 (4.5).
//  5. clear_i after 4 accepts, then 9 x 1.0 -> 32'h4110_0000; repeat with rst_n_i=0
//     instead of clear_i -> same result, ready_o=0 during reset, all outputs 0.
//  6. LEN=1: stream 3F80_0000, 4000_0000 with ready_i=1 -> two sums 1.0, 2.0 on
//     consecutive cycles, no bubble.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 constants and accumulator state encoding
package fp_pkg;

  localparam int FP_WIDTH = 32;
  localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_WIDTH-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [FP_WIDTH-1:0] FP_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RUN  = 2'd1,
    ACC_DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/floating_adder_sim.sv
// rtl/floating_adder_sim.sv - combinational FP32 adder, round-to-nearest-even
module floating_adder_sim
  import fp_pkg::*;
(
  input  logic [FP_WIDTH-1:0] a_i,
  input  logic [FP_WIDTH-1:0] b_i,
  output logic [FP_WIDTH-1:0] s_o
);

  logic        a_nan, b_nan, a_inf, b_inf;
  logic        sl, ss, st, rup;
  logic [7:0]  el, es, ef;
  logic [22:0] fl, fs;
  logic [8:0]  e_l, e_s, d, sh, en;
  logic [23:0] m_l, m_s;
  logic [26:0] aa, bx, bb, n;
  logic [27:0] sum28;
  logic [4:0]  lz;

  assign a_nan = (&a_i[30:23]) & (|a_i[22:0]);
  assign b_nan = (&b_i[30:23]) & (|b_i[22:0]);
  assign a_inf = (&a_i[30:23]) & ~(|a_i[22:0]);
  assign b_inf = (&b_i[30:23]) & ~(|b_i[22:0]);

  always_comb begin
    s_o   = FP_ZERO;
    sl    = a_i[31];
    el    = a_i[30:23];
    fl    = a_i[22:0];
    ss    = b_i[31];
    es    = b_i[30:23];
    fs    = b_i[22:0];
    e_l   = 9'd1;
    e_s   = 9'd1;
    m_l   = '0;
    m_s   = '0;
    d     = '0;
    aa    = '0;
    bx    = '0;
    bb    = '0;
    st    = 1'b0;
    sum28 = '0;
    n     = '0;
    lz    = '0;
    sh    = '0;
    en    = '0;
    ef    = '0;
    rup   = 1'b0;

    if (a_i[30:0] < b_i[30:0]) begin
      sl = b_i[31];
      el = b_i[30:23];
      fl = b_i[22:0];
      ss = a_i[31];
      es = a_i[30:23];
      fs = a_i[22:0];
    end

    if (a_nan || b_nan) begin
      s_o = FP_QNAN;
    end else if (a_inf && b_inf) begin
      s_o = (a_i[31] == b_i[31]) ? a_i : FP_QNAN;
    end else if (a_inf) begin
      s_o = a_i;
    end else if (b_inf) begin
      s_o = b_i;
    end else begin
      // Subnormals use exponent 1 with no hidden bit
      e_l = (el == 8'd0) ? 9'd1 : {1'b0, el};
      e_s = (es == 8'd0) ? 9'd1 : {1'b0, es};
      m_l = {el != 8'd0, fl};
      m_s = {es != 8'd0, fs};
      d   = e_l - e_s;
      aa  = {m_l, 3'b000};
      bx  = {m_s, 3'b000};
      if (d >= 9'd27) begin
        bb = '0;
        st = |bx;
      end else begin
        bb = bx >> d;
        st = |(bx & ((27'd1 << d) - 27'd1));
      end
      bb[0] = bb[0] | st;
      sum28 = (sl == ss) ? ({1'b0, aa} + {1'b0, bb}) : ({1'b0, aa} - {1'b0, bb});

      if (sum28 == 28'd0) begin
        s_o = {sl & ss, 31'd0};
      end else begin
        if (sum28[27]) begin
          n    = sum28[27:1];
          n[0] = sum28[1] | sum28[0];
          en   = e_l + 9'd1;
        end else begin
          for (int i = 0; i < 27; i++) begin
            if (sum28[i]) lz = 5'(26 - i);
          end
          // Never normalise below the minimum exponent: leaves a subnormal
          sh = ({4'd0, lz} < e_l) ? {4'd0, lz} : (e_l - 9'd1);
          n  = sum28[26:0] << sh;
          en = e_l - sh;
        end
        if (en >= 9'd255) begin
          s_o = {sl, FP_INF[30:0]};
        end else begin
          ef  = n[26] ? en[7:0] : 8'd0;
          rup = n[2] & (n[1] | n[0] | n[3]);
          s_o = {sl, {ef, n[25:3]} + {30'd0, rup}};
        end
      end
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - sums LEN FP32 products per window in arrival order
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN   = 9
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
  localparam acc_state_t FIRST_NEXT = (LEN == 1) ? ACC_DONE : ACC_RUN;

  acc_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] add_s;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             out_fire;

  floating_adder_sim u_add (
    .a_i (acc),
    .b_i (data_i),
    .s_o (add_s)
  );

  assign ready_o  = rst_n_i & ((state != ACC_DONE) | ready_i);
  assign accept   = valid_i & ready_o;
  assign valid_o  = (state == ACC_DONE);
  assign out_fire = valid_o & ready_i;
  assign busy_o   = (state == ACC_RUN);
  assign sum_o    = acc;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      state <= ACC_IDLE;
      acc   <= FP_ZERO;
      cnt   <= '0;
    end else begin
      case (state)
        ACC_IDLE: begin
          // First element is loaded rather than added so -0.0 is preserved
          if (accept) begin
            acc   <= data_i;
            cnt   <= CNT_W'(1);
            state <= FIRST_NEXT;
          end
        end
        ACC_RUN: begin
          if (accept) begin
            acc <= add_s;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) state <= ACC_DONE;
          end
        end
        ACC_DONE: begin
          if (out_fire) begin
            if (accept) begin
              acc   <= data_i;
              cnt   <= CNT_W'(1);
              state <= FIRST_NEXT;
            end else begin
              state <= ACC_IDLE;
            end
          end
        end
        default: state <= ACC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// tb/tb_fp_accumulator.sv - scoreboard bench for fp_accumulator (LEN=9 and LEN=1)
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n_i, clear_i, valid_i, ready_i;
  logic [31:0] data_i;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] sum_o;

  logic        v1, r1;
  logic [31:0] d1;
  logic        ready1, valid1, busy1;
  logic [31:0] sum1;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb[$];
  logic [31:0] win[$];

  always #5 clk = ~clk;

  fp_accumulator #(.WIDTH(32), .LEN(9)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .clear_i(clear_i), .valid_i(valid_i),
    .data_i(data_i), .ready_o(ready_o), .sum_o(sum_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o)
  );

  fp_accumulator #(.WIDTH(32), .LEN(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n_i), .clear_i(1'b0), .valid_i(v1),
    .data_i(d1), .ready_o(ready1), .sum_o(sum1), .valid_o(valid1),
    .ready_i(r1), .busy_o(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] int_to_fp(input int v);
    logic        s;
    int          a;
    int          msb;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    s = (v < 0);
    a = s ? -v : v;
    msb = 0;
    for (int i = 0; i < 31; i++) if (a[i]) msb = i;
    m = 32'(a) << (23 - msb);
    return {s, 8'(127 + msb), m[22:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n_i && !clear_i && valid_o && ready_i) begin
      if (sb.size() == 0) check("sb_extra", {31'd0, valid_o}, 32'd0);
      else check("sum", sum_o, sb.pop_front());
    end
  end

  task automatic send(input logic [31:0] d);
    int n;
    valid_i = 1'b1;
    data_i  = d;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("send_timeout", n, 32'd0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic run_window(input logic [31:0] exp);
    sb.push_back(exp);
    while (win.size() > 0) send(win.pop_front());
  endtask

  task automatic fill(input logic [31:0] first, input logic [31:0] rest);
    win.delete();
    win.push_back(first);
    for (int i = 1; i < 9; i++) win.push_back(rest);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int v;
    rst_n_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    v1 = 1'b0; r1 = 1'b1; d1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_sum", sum_o, 32'h0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;

    // 1: nine ones back-to-back, single-cycle valid
    sb.push_back(32'h4110_0000);
    for (int i = 0; i < 8; i++) send(32'h3F80_0000);
    check("t1_valid_early", {31'd0, valid_o}, 32'd0);
    send(32'h3F80_0000);
    check("t1_valid", {31'd0, valid_o}, 32'd1);
    check("t1_sum", sum_o, 32'h4110_0000);
    @(posedge clk); #1;
    check("t1_valid_1cyc", {31'd0, valid_o}, 32'd0);

    // 2: alternating signs with gaps
    sb.push_back(32'h3F80_0000);
    for (int i = 0; i < 9; i++) begin
      send(i[0] ? 32'hBF80_0000 : 32'h3F80_0000);
      if (i < 8) begin
        @(negedge clk);
        check("t2_busy_gap", {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    // 3: negative zeros
    fill(32'h8000_0000, 32'h8000_0000);
    run_window(32'h8000_0000);
    @(posedge clk); #1;

    // 4: downstream stall then back-to-back second window
    ready_i = 1'b0;
    fill(32'h3F80_0000, 32'h3F80_0000);
    run_window(32'h4110_0000);
    valid_i = 1'b1;
    data_i  = 32'h3F00_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, valid_o}, 32'd1);
      check("t4_hold_sum", sum_o, 32'h4110_0000);
      check("t4_hold_ready", {31'd0, ready_o}, 32'd0);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    sb.push_back(32'h4090_0000);
    send(32'h3F00_0000);
    check("t4_first_taken", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 8; i++) send(32'h3F00_0000);
    @(posedge clk); #1;

    // 5a: clear after four accepts
    for (int i = 0; i < 4; i++) send(32'h3F80_0000);
    valid_i = 1'b1; data_i = 32'h3F80_0000; clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0; valid_i = 1'b0;
    check("t5_clr_busy", {31'd0, busy_o}, 32'd0);
    check("t5_clr_sum", sum_o, 32'h0);
    fill(32'h3F80_0000, 32'h3F80_0000);
    run_window(32'h4110_0000);
    @(posedge clk); #1;

    // 5b: reset after four accepts
    for (int i = 0; i < 4; i++) send(32'h3F80_0000);
    valid_i = 1'b1; data_i = 32'h3F80_0000; rst_n_i = 1'b0;
    @(negedge clk);
    check("t5_rst_ready", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    check("t5_rst_ready2", {31'd0, ready_o}, 32'd0);
    check("t5_rst_sum", sum_o, 32'h0);
    check("t5_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t5_rst_valid", {31'd0, valid_o}, 32'd0);
    rst_n_i = 1'b1; valid_i = 1'b0;
    fill(32'h3F80_0000, 32'h3F80_0000);
    run_window(32'h4110_0000);
    @(posedge clk); #1;

    // Rounding ties-to-even and infinity propagation
    fill(32'h4B80_0000, 32'h3F80_0000);
    run_window(32'h4B80_0000);
    fill(32'h4B80_0001, 32'h3F80_0000);
    run_window(32'h4B80_0002);
    fill(32'h7F80_0000, 32'h3F80_0000);
    run_window(32'h7F80_0000);

    // Random small-integer windows: exact, order-independent sums
    for (int w = 0; w < 6; w++) begin
      win.delete();
      s = 0;
      for (int i = 0; i < 9; i++) begin
        v = int'($urandom_range(40)) - 20;
        s += v;
        win.push_back(int_to_fp(v));
      end
      run_window(int_to_fp(s));
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sb_drain", sb.size(), 32'd0);

    // 6: LEN=1 instance, two sums on consecutive cycles
    v1 = 1'b1; d1 = 32'h3F80_0000;
    @(posedge clk); #1;
    check("t6_valid_a", {31'd0, valid1}, 32'd1);
    check("t6_sum_a", sum1, 32'h3F80_0000);
    check("t6_ready", {31'd0, ready1}, 32'd1);
    d1 = 32'h4000_0000;
    @(posedge clk); #1;
    check("t6_valid_b", {31'd0, valid1}, 32'd1);
    check("t6_sum_b", sum1, 32'h4000_0000);
    v1 = 1'b0;
    @(posedge clk); #1;
    check("t6_valid_end", {31'd0, valid1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
